// File: rtl/brq_tlul_host_arb.sv
// Multi-host TL-UL arbiter: selects one core request per cycle onto a single A channel and returns
// per-host responses in request order, re-ordering D beats through a per-host slot buffer.

package brq_tlul_pkg;
  parameter int TL_AW  = 32;
  parameter int TL_DW  = 32;
  parameter int TL_AIW = 8;
  parameter int TL_DIW = 1;
  parameter int TL_SZW = 2;
  parameter int TL_DBW = 4;

  parameter logic [2:0] PutFullData    = 3'h0;
  parameter logic [2:0] PutPartialData = 3'h1;
  parameter logic [2:0] Get            = 3'h4;
  parameter logic [2:0] AccessAck      = 3'h0;
  parameter logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module brq_tlul_host_arb
  import brq_tlul_pkg::*;
#(
  parameter int NumHosts = 2,
  parameter int MaxReqs  = 2,
  parameter int ArbMode  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumHosts-1:0]      host_req_i,
  output logic [NumHosts-1:0]      host_gnt_o,
  input  logic [NumHosts-1:0][31:0] host_addr_i,
  input  logic [NumHosts-1:0]      host_we_i,
  input  logic [NumHosts-1:0][3:0] host_be_i,
  input  logic [NumHosts-1:0][31:0] host_wdata_i,
  output logic [NumHosts-1:0]      host_rvalid_o,
  output logic [NumHosts-1:0][31:0] host_rdata_o,
  output logic [NumHosts-1:0]      host_err_o,
  output tl_h2d_t                  tl_h_o,
  input  tl_d2h_t                  tl_h_i,
  output logic                     rsp_unexp_o
);

  localparam int SlotBits = $clog2(MaxReqs);
  localparam int HostBits = $clog2(NumHosts);
  localparam int PW       = (SlotBits > 0) ? SlotBits : 1;
  localparam int HW       = (HostBits > 0) ? HostBits : 1;
  localparam int CW       = $clog2(MaxReqs + 1);

  if (NumHosts < 1 || NumHosts > 4) begin : gen_bad_num_hosts
    $error("NumHosts must be in 1..4");
  end
  if (MaxReqs < 1 || MaxReqs > 8 || (MaxReqs & (MaxReqs - 1)) != 0) begin : gen_bad_max_reqs
    $error("MaxReqs must be a power of two in 1..8");
  end
  if (HostBits + SlotBits > TL_AIW) begin : gen_bad_source_width
    $error("host index and slot do not fit in a_source");
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == MaxReqs - 1) ? '0 : p + PW'(1);
  endfunction

  logic [PW-1:0]      wptr_q     [NumHosts];
  logic [PW-1:0]      rptr_q     [NumHosts];
  logic [CW-1:0]      cnt_q      [NumHosts];
  logic [MaxReqs-1:0] pend_q     [NumHosts];
  logic [MaxReqs-1:0] done_q     [NumHosts];
  logic [MaxReqs-1:0] buf_err_q  [NumHosts];
  logic [31:0]        buf_data_q [NumHosts][MaxReqs];
  logic [HW-1:0]      rr_q;

  logic [NumHosts-1:0] elig;
  logic [HW-1:0]       sel_idx;
  logic                sel_found;
  int                  cand;
  logic                a_valid;
  logic                a_fire;

  always_comb begin
    elig = '0;
    for (int h = 0; h < NumHosts; h++) begin
      elig[h] = host_req_i[h] && (cnt_q[h] < CW'(MaxReqs));
    end
  end

  // Round robin scans upward from rr_q; fixed priority scans from host 0.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = 0;
    for (int i = 0; i < NumHosts; i++) begin
      cand = (ArbMode == 1) ? (int'(rr_q) + i) % NumHosts : i;
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_idx   = HW'(cand);
      end
    end
  end

  assign a_valid = sel_found & ~rst_i;
  assign a_fire  = a_valid & tl_h_i.a_ready;

  always_comb begin
    host_gnt_o = '0;
    if (a_fire) host_gnt_o[sel_idx] = 1'b1;
  end

  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = a_valid;
    tl_h_o.a_size    = 2'd2;
    tl_h_o.a_source  = TL_AIW'((int'(sel_idx) << SlotBits) | int'(wptr_q[sel_idx]));
    tl_h_o.a_address = host_addr_i[sel_idx] & 32'hFFFF_FFFC;
    tl_h_o.a_data    = host_wdata_i[sel_idx];
    tl_h_o.d_ready   = 1'b1;
    if (!host_we_i[sel_idx]) begin
      tl_h_o.a_opcode = Get;
      tl_h_o.a_mask   = 4'hF;
    end else if (host_be_i[sel_idx] == 4'hF) begin
      tl_h_o.a_opcode = PutFullData;
      tl_h_o.a_mask   = 4'hF;
    end else begin
      tl_h_o.a_opcode = PutPartialData;
      tl_h_o.a_mask   = host_be_i[sel_idx];
    end
  end

  // D channel decode: host index is everything above the slot field.
  int                       d_host;
  logic [PW-1:0]            d_slot;
  logic [NumHosts-1:0]      d_hit;
  logic [NumHosts-1:0]      d_direct;
  logic [NumHosts-1:0]      retire;
  logic [NumHosts-1:0][31:0] ret_data;
  logic [NumHosts-1:0]      ret_err;

  assign d_host = int'(tl_h_i.d_source >> SlotBits);
  assign d_slot = PW'(int'(tl_h_i.d_source) & (MaxReqs - 1));

  always_comb begin
    d_hit    = '0;
    d_direct = '0;
    retire   = '0;
    ret_data = '0;
    ret_err  = '0;
    for (int h = 0; h < NumHosts; h++) begin
      d_hit[h] = tl_h_i.d_valid && (d_host == h) &&
                 pend_q[h][d_slot] && !done_q[h][d_slot];
      // A beat for the oldest slot retires straight to the core without buffering.
      d_direct[h] = d_hit[h] && (d_slot == rptr_q[h]);
      retire[h]   = done_q[h][rptr_q[h]] | d_direct[h];
      if (done_q[h][rptr_q[h]]) begin
        ret_data[h] = buf_data_q[h][rptr_q[h]];
        ret_err[h]  = buf_err_q[h][rptr_q[h]];
      end else begin
        ret_data[h] = tl_h_i.d_data;
        ret_err[h]  = tl_h_i.d_error;
      end
    end
  end

  assign rsp_unexp_o = tl_h_i.d_valid & ~(|d_hit) & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q          <= '0;
      host_rvalid_o <= '0;
      host_rdata_o  <= '0;
      host_err_o    <= '0;
      for (int h = 0; h < NumHosts; h++) begin
        wptr_q[h]    <= '0;
        rptr_q[h]    <= '0;
        cnt_q[h]     <= '0;
        pend_q[h]    <= '0;
        done_q[h]    <= '0;
        buf_err_q[h] <= '0;
        for (int s = 0; s < MaxReqs; s++) buf_data_q[h][s] <= '0;
      end
    end else begin
      if (a_fire) begin
        rr_q <= (int'(sel_idx) == NumHosts - 1) ? '0 : sel_idx + HW'(1);
      end
      for (int h = 0; h < NumHosts; h++) begin
        host_rvalid_o[h] <= retire[h];
        if (retire[h]) begin
          host_rdata_o[h]          <= ret_data[h];
          host_err_o[h]            <= ret_err[h];
          pend_q[h][rptr_q[h]]     <= 1'b0;
          done_q[h][rptr_q[h]]     <= 1'b0;
          rptr_q[h]                <= ptr_inc(rptr_q[h]);
        end
        if (host_gnt_o[h]) begin
          pend_q[h][wptr_q[h]] <= 1'b1;
          done_q[h][wptr_q[h]] <= 1'b0;
          wptr_q[h]            <= ptr_inc(wptr_q[h]);
        end
        if (d_hit[h] && !d_direct[h]) begin
          buf_data_q[h][d_slot] <= tl_h_i.d_data;
          buf_err_q[h][d_slot]  <= tl_h_i.d_error;
          done_q[h][d_slot]     <= 1'b1;
        end
        if (host_gnt_o[h] && !retire[h]) begin
          cnt_q[h] <= cnt_q[h] + CW'(1);
        end else if (!host_gnt_o[h] && retire[h]) begin
          cnt_q[h] <= cnt_q[h] - CW'(1);
        end
      end
    end
  end

  logic unused_d_fields;
  assign unused_d_fields = ^{tl_h_i.d_opcode, tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink};

endmodule

// File: tb/tb_brq_tlul_host_arb.sv
// Directed bench for brq_tlul_host_arb: fixed-priority instance for most checks, a round-robin
// instance sharing the same stimulus for the alternation check.

module tb_brq_tlul_host_arb;
  import brq_tlul_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic [1:0]       we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] wdata;
  tl_d2h_t          tl_d;

  logic [1:0]       gnt, rvalid, err;
  logic [1:0][31:0] rdata;
  tl_h2d_t          tl_h;
  logic             unexp;

  logic [1:0]       gnt_rr, rvalid_rr, err_rr;
  logic [1:0][31:0] rdata_rr;
  tl_h2d_t          tl_h_rr;
  logic             unexp_rr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  brq_tlul_host_arb #(.NumHosts(2), .MaxReqs(2), .ArbMode(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .host_req_i(req), .host_gnt_o(gnt),
    .host_addr_i(addr), .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata),
    .host_rvalid_o(rvalid), .host_rdata_o(rdata), .host_err_o(err),
    .tl_h_o(tl_h), .tl_h_i(tl_d), .rsp_unexp_o(unexp)
  );

  brq_tlul_host_arb #(.NumHosts(2), .MaxReqs(2), .ArbMode(1)) u_dut_rr (
    .clk_i(clk), .rst_i(rst), .host_req_i(req), .host_gnt_o(gnt_rr),
    .host_addr_i(addr), .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata),
    .host_rvalid_o(rvalid_rr), .host_rdata_o(rdata_rr), .host_err_o(err_rr),
    .tl_h_o(tl_h_rr), .tl_h_i(tl_d), .rsp_unexp_o(unexp_rr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic d_beat(input logic [7:0] src, input logic [31:0] data, input logic e);
    tl_d.d_valid  = 1'b1;
    tl_d.d_source = src;
    tl_d.d_data   = data;
    tl_d.d_error  = e;
    tl_d.d_opcode = AccessAckData;
  endtask

  task automatic d_idle();
    tl_d.d_valid  = 1'b0;
    tl_d.d_source = '0;
    tl_d.d_data   = '0;
    tl_d.d_error  = 1'b0;
  endtask

  logic [1:0] exp_fix [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
  logic [1:0] exp_rr  [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
  logic [7:0] exp_src [4] = '{8'd0, 8'd1, 8'd2, 8'd3};

  initial begin
    rst   = 1'b1;
    req   = '0;
    addr  = '0;
    we    = '0;
    be    = '0;
    wdata = '0;
    tl_d  = '0;
    tl_d.a_ready = 1'b1;
    repeat (2) cyc();

    // Reset state, with a request and a D beat present.
    req = 2'b11;
    d_beat(8'd0, 32'h5555_5555, 1'b0);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_gnt_rr", 32'(gnt_rr), 32'h0);
    check_eq("rst_a_valid", 32'(tl_h.a_valid), 32'h0);
    check_eq("rst_unexp", 32'(unexp), 32'h0);
    check_eq("rst_rvalid", 32'(rvalid), 32'h0);
    check_eq("rst_rdata0", rdata[0], 32'h0);
    check_eq("rst_d_ready", 32'(tl_h.d_ready), 32'h1);
    req = '0;
    d_idle();
    cyc();
    rst = 1'b0;

    // Arbitration: both hosts request continuously.
    req  = 2'b11;
    addr = {32'h0000_0200, 32'h0000_0100};
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("arb_fix_%0d", i), 32'(gnt), 32'(exp_fix[i]));
      check_eq($sformatf("arb_rr_%0d", i), 32'(gnt_rr), 32'(exp_rr[i]));
      if (i < 4) check_eq($sformatf("arb_src_%0d", i), 32'(tl_h.a_source), 32'(exp_src[i]));
      cyc();
    end

    // All full: stray source, then a real retire re-opens host 0.
    d_beat(8'h07, 32'h0, 1'b0);
    #1;
    check_eq("full_unexp_src7", 32'(unexp), 32'h1);
    check_eq("full_gnt", 32'(gnt), 32'h0);
    cyc();
    d_beat(8'h00, 32'h0000_A5A5, 1'b0);
    #1;
    check_eq("full_beat_unexp", 32'(unexp), 32'h0);
    check_eq("full_no_bypass", 32'(gnt), 32'h0);
    cyc();
    d_idle();
    #1;
    check_eq("full_retire_rvalid", 32'(rvalid), 32'h1);
    check_eq("full_retire_rdata", rdata[0], 32'h0000_A5A5);
    check_eq("full_regrant", 32'(gnt), 32'h1);
    req = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Single read on host 0.
    req = 2'b01;
    we = '0;
    addr[0] = 32'h1000_0004;
    #1;
    check_eq("rd_gnt", 32'(gnt), 32'h1);
    check_eq("rd_a_valid", 32'(tl_h.a_valid), 32'h1);
    check_eq("rd_opcode", 32'(tl_h.a_opcode), 32'(Get));
    check_eq("rd_source", 32'(tl_h.a_source), 32'h0);
    check_eq("rd_addr", tl_h.a_address, 32'h1000_0004);
    check_eq("rd_mask", 32'(tl_h.a_mask), 32'hF);
    check_eq("rd_size", 32'(tl_h.a_size), 32'h2);
    cyc();
    req = '0;
    d_beat(8'h00, 32'hDEAD_BEEF, 1'b0);
    #1;
    check_eq("rd_d_unexp", 32'(unexp), 32'h0);
    check_eq("rd_rvalid_early", 32'(rvalid), 32'h0);
    cyc();
    d_idle();
    #1;
    check_eq("rd_rvalid", 32'(rvalid), 32'h1);
    check_eq("rd_rdata", rdata[0], 32'hDEAD_BEEF);
    check_eq("rd_err", 32'(err), 32'h0);
    cyc();
    #1;
    check_eq("rd_rvalid_pulse", 32'(rvalid), 32'h0);

    // Partial write with error response; host 0 now on slot 1.
    req = 2'b01;
    we[0] = 1'b1;
    be[0] = 4'b0011;
    wdata[0] = 32'h1234_5678;
    addr[0] = 32'h2000_0013;
    #1;
    check_eq("pw_opcode", 32'(tl_h.a_opcode), 32'(PutPartialData));
    check_eq("pw_mask", 32'(tl_h.a_mask), 32'h3);
    check_eq("pw_data", tl_h.a_data, 32'h1234_5678);
    check_eq("pw_addr_align", tl_h.a_address, 32'h2000_0010);
    check_eq("pw_source", 32'(tl_h.a_source), 32'h1);
    cyc();
    req = '0;
    d_beat(8'h01, 32'h0, 1'b1);
    tl_d.d_opcode = AccessAck;
    cyc();
    d_idle();
    #1;
    check_eq("pw_rvalid", 32'(rvalid), 32'h1);
    check_eq("pw_err", 32'(err), 32'h1);

    // Full write wraps back to slot 0.
    req = 2'b01;
    be[0] = 4'hF;
    #1;
    check_eq("fw_opcode", 32'(tl_h.a_opcode), 32'(PutFullData));
    check_eq("fw_mask", 32'(tl_h.a_mask), 32'hF);
    check_eq("fw_source", 32'(tl_h.a_source), 32'h0);
    cyc();
    req = '0;
    we = '0;
    d_beat(8'h00, 32'h0, 1'b0);
    cyc();
    d_idle();
    #1;
    check_eq("fw_rvalid", 32'(rvalid), 32'h1);
    check_eq("fw_err", 32'(err), 32'h0);

    // Host 1: two reads answered out of order, with a duplicate beat in between.
    req = 2'b10;
    addr[1] = 32'h3000_0000;
    #1;
    check_eq("ooo_gnt0", 32'(gnt), 32'h2);
    check_eq("ooo_src0", 32'(tl_h.a_source), 32'h2);
    cyc();
    #1;
    check_eq("ooo_gnt1", 32'(gnt), 32'h2);
    check_eq("ooo_src1", 32'(tl_h.a_source), 32'h3);
    cyc();
    req = '0;
    d_beat(8'h03, 32'h0000_1111, 1'b0);
    #1;
    check_eq("ooo_slot1_unexp", 32'(unexp), 32'h0);
    cyc();
    d_beat(8'h03, 32'h0000_9999, 1'b0);
    #1;
    check_eq("ooo_dup_unexp", 32'(unexp), 32'h1);
    check_eq("ooo_hold", 32'(rvalid), 32'h0);
    cyc();
    d_beat(8'h02, 32'h0000_2222, 1'b0);
    #1;
    check_eq("ooo_slot0_unexp", 32'(unexp), 32'h0);
    check_eq("ooo_still_hold", 32'(rvalid), 32'h0);
    cyc();
    d_idle();
    #1;
    check_eq("ooo_rvalid_a", 32'(rvalid), 32'h2);
    check_eq("ooo_rdata_a", rdata[1], 32'h0000_2222);
    cyc();
    #1;
    check_eq("ooo_rvalid_b", 32'(rvalid), 32'h2);
    check_eq("ooo_rdata_b", rdata[1], 32'h0000_1111);
    cyc();
    #1;
    check_eq("ooo_rvalid_end", 32'(rvalid), 32'h0);

    // Reset with outstanding reads; host 0 slots are 1 then 0 here.
    req = 2'b01;
    addr[0] = 32'h4000_0000;
    #1;
    check_eq("rr_gnt_a", 32'(gnt), 32'h1);
    cyc();
    #1;
    check_eq("rr_gnt_b", 32'(gnt), 32'h1);
    cyc();
    req = '0;
    d_beat(8'h01, 32'h0000_7777, 1'b0);
    cyc();
    d_idle();
    #1;
    check_eq("mid_rvalid", 32'(rvalid), 32'h1);
    check_eq("mid_rdata", rdata[0], 32'h0000_7777);
    #1;
    rst = 1'b1;
    req = 2'b01;
    #1;
    check_eq("async_rvalid", 32'(rvalid), 32'h0);
    check_eq("async_rdata", rdata[0], 32'h0);
    check_eq("async_gnt", 32'(gnt), 32'h0);
    check_eq("async_a_valid", 32'(tl_h.a_valid), 32'h0);
    req = '0;
    cyc();
    rst = 1'b0;
    d_beat(8'h00, 32'h0000_8888, 1'b0);
    #1;
    check_eq("late_unexp_a", 32'(unexp), 32'h1);
    cyc();
    d_beat(8'h01, 32'h0000_8888, 1'b0);
    #1;
    check_eq("late_unexp_b", 32'(unexp), 32'h1);
    check_eq("late_rvalid_a", 32'(rvalid), 32'h0);
    cyc();
    d_idle();
    #1;
    check_eq("late_rvalid_b", 32'(rvalid), 32'h0);
    check_eq("late_unexp_idle", 32'(unexp), 32'h0);
    cyc();
    #1;
    check_eq("late_rvalid_c", 32'(rvalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
